// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - execute-stage multiply/divide unit owning HI/LO
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        req_cancel,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] mdu_rd
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t        state, next_state;
    logic [CW-1:0] count, next_count;
    logic [31:0]   hi, lo, next_hi, next_lo;
    logic [31:0]   op_a, op_b;
    logic          op_signed;

    logic [63:0]   ext_a, ext_b, product;
    logic          a_neg, b_neg;
    logic [31:0]   mag_a, mag_b, div_safe, uq, ur, quot, rem;

    assign busy   = (state != IDLE);
    assign start  = (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU) && !req_cancel && !busy;
    assign hi_out = hi;
    assign lo_out = lo;
    assign mdu_rd = (mdu_op == OP_MFHI) ? hi : (mdu_op == OP_MFLO) ? lo : 32'd0;

    // Sign-extending to 64 bits makes one truncated multiply serve both signednesses.
    always_comb begin
        ext_a   = {{32{op_signed & op_a[31]}}, op_a};
        ext_b   = {{32{op_signed & op_b[31]}}, op_b};
        product = ext_a * ext_b;
    end

    // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
    always_comb begin
        a_neg    = op_signed & op_a[31];
        b_neg    = op_signed & op_b[31];
        mag_a    = a_neg ? (32'd0 - op_a) : op_a;
        mag_b    = b_neg ? (32'd0 - op_b) : op_b;
        div_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;
        uq       = mag_a / div_safe;
        ur       = mag_a % div_safe;
        quot     = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem      = a_neg ? (32'd0 - ur) : ur;
    end

    always_comb begin
        next_state = state;
        next_count = count;
        next_hi    = hi;
        next_lo    = lo;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mdu_op == OP_MULT || mdu_op == OP_MULTU) begin
                        next_state = MUL;
                        next_count = CW'(MULT_CYCLES);
                    end else begin
                        next_state = DIV;
                        next_count = CW'(DIV_CYCLES);
                    end
                end else if (!req_cancel) begin
                    if (mdu_op == OP_MTHI) next_hi = rs_val;
                    if (mdu_op == OP_MTLO) next_lo = rs_val;
                end
            end
            MUL: begin
                next_count = count - 1'b1;
                if (count == CW'(1)) begin
                    next_state = IDLE;
                    next_hi    = product[63:32];
                    next_lo    = product[31:0];
                end
            end
            DIV: begin
                next_count = count - 1'b1;
                if (count == CW'(1)) begin
                    next_state = IDLE;
                    if (op_b != 32'd0) begin
                        next_hi = rem;
                        next_lo = quot;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= next_state;
            count <= next_count;
            hi    <= next_hi;
            lo    <= next_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            op_a      <= rs_val;
            op_b      <= rt_val;
            op_signed <= (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
        end
    end

endmodule
